quad_decoder: RTL

- Decodes a two-phase quadrature signal pair (a, b) from a rotary/linear encoder into a signed step stream and a wrapping position count.
- This is the sensing end of the up/down counting path: it turns physical phase transitions into up/down events, synchronises and glitch-filters the asynchronous inputs, and flags illegal transitions.

---
 rtl/quad_decoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder decoder with synchroniser, glitch filter and wrapping position count
//
// Ports:
//   clk      system clock, rising edge
//   clear_n  synchronous active-low reset
//   a, b     encoder phases, asynchronous to clk
//   zero     synchronous position clear (wins over a simultaneous step)
//   pos      position count, modulo 2^WIDTH
//   dir      direction of the last accepted step (1 = up)
//   step     one-cycle pulse per accepted transition
//   err      sticky flag for a two-bit (illegal) phase jump
module quad_decoder #(
    parameter int WIDTH = 8,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             a,
    input  logic             b,
    input  logic             zero,
    output logic [WIDTH-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    // All per-phase vectors are ordered {b, a}.
    logic [1:0]          s1_q, s1_d;
    logic [1:0]          s2_q, s2_d;
    logic [1:0]          filt_q, filt_d;
    logic [1:0]          prev_q, prev_d;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic [2:0]          warm_q, warm_d;
    logic [WIDTH-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic                step_q, step_d;
    logic                err_q, err_d;

    always_comb begin
        s1_d   = {b, a};
        s2_d   = s1_q;
        filt_d = filt_q;
        prev_d = filt_q;
        cnt_d  = cnt_q;
        warm_d = warm_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        err_d  = err_q;

        if (warm_q != 3'd0) begin
            // Track the inputs directly so a resting non-00 phase is
            // adopted silently instead of looking like a transition.
            warm_d = warm_q - 3'd1;
            filt_d = s2_q;
            cnt_d  = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        filt_d[i] = s2_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end

            case ({prev_q, filt_q})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    pos_d  = pos_q + WIDTH'(1);
                end
                4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    pos_d  = pos_q - WIDTH'(1);
                end
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                    err_d = 1'b1;
                end
                default: begin
                end
            endcase
        end

        if (zero) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            filt_q <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
            warm_q <= 3'd4;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            filt_q <= filt_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            warm_q <= warm_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            err_q  <= err_d;
        end
    end

    assign pos  = pos_q;
    assign dir  = dir_q;
    assign step = step_q;
    assign err  = err_q;

endmodule
